imem_program_encoder: RTL and testbench
=======================================

# imem_program_encoder

Instruction-memory programmer for the single-cycle RV32I core: it is the encoding counterpart of the control unit's decode path. It accepts field-level instruction commands over a valid/ready stream, assembles them into 32-bit RISC-V words for the same instruction subset the control unit decodes, and writes them sequentially into I_mem. While programming is in progress it holds the core off; when programming completes it releases the core.

## Interface
- `DEPTH`, 64: instruction-memory capacity in words.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a programming session.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_last` in 1: marks the final command of a session.
- `cmd_kind` in 3: 0=LW, 1=SW, 2=R, 3=I-ALU, 4=BRANCH; 5–7 are illegal.
- `cmd_funct3` in 3, `cmd_alt` in 1 (funct7[5]), `cmd_rd`/`cmd_rs1`/`cmd_rs2` in 5 each.
- `cmd_imm` in 13: signed immediate. LW/SW/I use [11:0]; BRANCH uses [12:1].
- `imem_we` out 1, `imem_addr` out 32, `imem_wdata` out 32: I_mem write port.
- `cpu_hold` out 1: high means the core's PC must not advance.
- `done` out 1, `err` out 1 (sticky, illegal command seen), `overflow` out 1 (sticky).
- `word_count` out $clog2(DEPTH+1): number of words written this session.

## Operation
- FSM states are IDLE, PROG, and DONE. Reset enters IDLE.
  - IDLE: `start` moves the FSM to PROG.
  - PROG: transitions to DONE once the final write has issued (see Timing).
  - DONE: `start` re-enters PROG and clears `word_count`, `err`, `overflow`, and the address index.
- `start` is ignored while in PROG.
- `cmd_ready` = (state==PROG) && !stop, where `stop` is set after accepting `cmd_last` or the DEPTH-th legal word.
- Encodings (opcodes match the decoder):
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}. `cmd_funct3` is ignored.
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}. `cmd_funct3` is ignored.
  - R: {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011}.
  - I: {imm[11:0], rs1, f3, rd, 7'b0010011}. When f3 is 001 or 101, bits [31:25] are forced to 0 and bits [24:20] = imm[4:0].
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011}.
- A command is illegal if any of the following holds:
  - `cmd_kind` is 5–7.
  - R/I with f3 = 010 or 011.
  - BRANCH with f3 not in {000, 001, 100}.
  - BRANCH with imm[0] = 1.
  - `cmd_alt` = 1 on anything other than R with f3 = 000.
- An illegal command is consumed without a write. It sets `err`, and the address does not advance.
- Address for each write = BASE_ADDR + 4·index. The index increments per legal write and never wraps.
- Overflow: if the DEPTH-th legal word is accepted without `cmd_last`, `overflow` is set and the session ends. Extra commands are never accepted.

## Timing
- Reset values:
  - state IDLE; `cmd_ready` 0; `imem_we` 0; `imem_addr` BASE_ADDR; `imem_wdata` 0.
  - `cpu_hold` 1, so the core is held from reset until the first session completes.
  - `done` 0; `err` 0; `overflow` 0; `word_count` 0.
- `start` sampled at cycle S: state is PROG and `cmd_ready` = 1 at S+1.
- Legal command accepted at cycle N: `imem_we` = 1 for exactly one cycle at N+1, with registered addr/data. `word_count` increments at N+2.
- Throughput is one word per cycle with `cmd_valid` held high.
- Session-ending accept at N (`cmd_last`, or DEPTH reached):
  - `cmd_ready` = 0 from N+1.
  - Final write, if legal, occurs at N+1.
  - `done` = 1 and `cpu_hold` = 0 at N+2 (state DONE).
  - This applies even when the last command is illegal.
- `done` stays high in DONE. It clears, and `cpu_hold` rises, the cycle after `start`.
- `cmd_valid` without `cmd_ready` has no effect.
- `rst` mid-session: all outputs take reset values the next cycle. A pending write is dropped (`imem_we` = 0).

## Test plan
- **addi:** Reset, `start`, one command I f3=000 rd=1 rs1=0 imm=5 with last → `imem_we` at addr 0x0 with 0x00500093; `done` = 1 and `cpu_hold` = 0 two cycles after the accept; `word_count` = 1.
- **Back-to-back mix, `cmd_valid` held:** lw x5,4(x1); sw x2,8(x1); sub x3,x1,x2; beq x1,x2,-8 (last) → consecutive writes 0x0040A283 @0, 0x0020A423 @4, 0x402081B3 @8, 0xFE208CE3 @12; `word_count` = 4.
- **Illegal then legal:** R f3=010, then addi (last) → no write for the first; `err` = 1; the addi is written at 0x0; `word_count` = 1.
- **Overflow, DEPTH=4:** five non-last legal commands offered → four writes at 0–12; `cmd_ready` low after the fourth accept; `overflow` = 1, `done` = 1; the fifth command is never accepted.
- **Reset mid-session:** `rst` one cycle after the second accept → no third write; `word_count` = 0, `cpu_hold` = 1, `done`/`err` = 0, state IDLE.
- **Restart from DONE:** `start` in DONE → `done` = 0 and `cpu_hold` = 1 next cycle; the next command is written at BASE_ADDR; `err`/`overflow` are cleared.

Source files
------------

// File: rtl/imem_program_encoder_if.sv
// -----------------------------------------------------------------------------
// imem_program_encoder_if
// Bundles the command stream into the encoder and the instruction-memory write
// port out of it.
//   cmd_valid/cmd_ready : command handshake (word transfers when both are high)
//   cmd_last            : final command of a programming session
//   cmd_kind            : 0=LW 1=SW 2=R 3=I-ALU 4=BRANCH (5..7 illegal)
//   cmd_funct3/cmd_alt  : funct3 and funct7[5]
//   cmd_rd/rs1/rs2      : register fields
//   cmd_imm             : signed immediate, [11:0] or [12:1] by kind
//   imem_we/addr/wdata  : registered I_mem write port
// master = command source / memory sink, slave = the encoder.
// -----------------------------------------------------------------------------
interface imem_program_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_last;
    logic [2:0]  cmd_kind;
    logic [2:0]  cmd_funct3;
    logic        cmd_alt;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [12:0] cmd_imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output cmd_valid, cmd_last, cmd_kind, cmd_funct3, cmd_alt,
               cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_last, cmd_kind, cmd_funct3, cmd_alt,
               cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_program_encoder.sv
// -----------------------------------------------------------------------------
// imem_program_encoder
// Programs I_mem for the single-cycle RV32I core. Field-level commands arrive
// on the bus, are assembled into 32-bit RISC-V words (LW, SW, R, I-ALU, BRANCH)
// and written to consecutive words starting at BASE_ADDR. The core is held
// (o_cpu_hold) from reset until a session completes, and again while a new
// session is running.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_start       : pulse that opens a session (ignored while programming)
//   bus           : command stream in, I_mem write port out (slave modport)
//   o_cpu_hold    : core PC must not advance
//   o_done        : session finished, stays high until the next start
//   o_err         : sticky, an illegal command was consumed
//   o_overflow    : sticky, DEPTH words filled before cmd_last
//   o_word_count  : words written in the current session
// -----------------------------------------------------------------------------
module imem_program_encoder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    imem_program_encoder_if.slave        bus,
    output logic                         o_cpu_hold,
    output logic                         o_done,
    output logic                         o_err,
    output logic                         o_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   o_word_count
);
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    localparam logic [2:0] KIND_LW = 3'd0;
    localparam logic [2:0] KIND_SW = 3'd1;
    localparam logic [2:0] KIND_R  = 3'd2;
    localparam logic [2:0] KIND_I  = 3'd3;
    localparam logic [2:0] KIND_BR = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_PROG, S_DONE} state_t;

    state_t          r_state;
    logic            r_stop;
    logic [CW-1:0]   r_index;
    logic [CW-1:0]   r_word_count;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_err;
    logic            r_overflow;
    logic            r_done;
    logic            r_cpu_hold;

    logic            w_legal;
    logic [31:0]     w_enc;
    logic            w_ready;
    logic            w_accept;
    logic            w_depth_hit;

    // Encoder and legality check for the command currently on the bus.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        w_legal = 1'b1;
        w_enc   = 32'h0;
        case (bus.cmd_kind)
            KIND_LW: w_enc = {bus.cmd_imm[11:0], bus.cmd_rs1, 3'b010, bus.cmd_rd, OP_LOAD};
            KIND_SW: w_enc = {bus.cmd_imm[11:5], bus.cmd_rs2, bus.cmd_rs1, 3'b010,
                              bus.cmd_imm[4:0], OP_STORE};
            KIND_R: begin
                w_enc = {1'b0, bus.cmd_alt, 5'b0, bus.cmd_rs2, bus.cmd_rs1,
                         bus.cmd_funct3, bus.cmd_rd, OP_R};
                if (bus.cmd_funct3[2:1] == 2'b01) w_legal = 1'b0;
            end
            KIND_I: begin
                // Shift-immediates carry only a 5-bit shamt; the upper field is zero.
                if (bus.cmd_funct3[1:0] == 2'b01)
                    w_enc = {7'b0, bus.cmd_imm[4:0], bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd, OP_I};
                else
                    w_enc = {bus.cmd_imm[11:0], bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd, OP_I};
                if (bus.cmd_funct3[2:1] == 2'b01) w_legal = 1'b0;
            end
            KIND_BR: begin
                w_enc = {bus.cmd_imm[12], bus.cmd_imm[10:5], bus.cmd_rs2, bus.cmd_rs1,
                         bus.cmd_funct3, bus.cmd_imm[4:1], bus.cmd_imm[11], OP_BRANCH};
                if (!(bus.cmd_funct3 inside {3'b000, 3'b001, 3'b100})) w_legal = 1'b0;
                if (bus.cmd_imm[0]) w_legal = 1'b0;
            end
            default: w_legal = 1'b0;
        endcase
        // funct7[5] is only meaningful for SUB.
        if (bus.cmd_alt && !(bus.cmd_kind == KIND_R && bus.cmd_funct3 == 3'b000))
            w_legal = 1'b0;
    end

    assign w_ready     = (r_state == S_PROG) && !r_stop;
    assign w_accept    = w_ready && bus.cmd_valid;
    assign w_depth_hit = w_legal && (r_index == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_stop       <= 1'b0;
            r_index      <= '0;
            r_word_count <= '0;
            r_we         <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= 32'h0;
            r_err        <= 1'b0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_hold   <= 1'b1;
        end else begin
            // NOTE: non-blocking throughout; the write strobe defaults low so
            // it is a single-cycle pulse, and later assignments below override.
            r_we <= 1'b0;
            if (r_we) r_word_count <= r_word_count + CW'(1);

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state      <= S_PROG;
                        r_stop       <= 1'b0;
                        r_index      <= '0;
                        r_word_count <= '0;
                        r_err        <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_done       <= 1'b0;
                        r_cpu_hold   <= 1'b1;
                    end
                end
                S_PROG: begin
                    if (r_stop) begin
                        // The final write issued last cycle; release the core.
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else if (w_accept) begin
                        if (w_legal) begin
                            r_we    <= 1'b1;
                            r_addr  <= BASE_ADDR + (32'(r_index) << 2);
                            r_wdata <= w_enc;
                            r_index <= r_index + CW'(1);
                        end else begin
                            r_err <= 1'b1;
                        end
                        if (bus.cmd_last || w_depth_hit) r_stop     <= 1'b1;
                        if (!bus.cmd_last && w_depth_hit) r_overflow <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = w_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_overflow     = r_overflow;
    assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_imem_program_encoder.sv
// -----------------------------------------------------------------------------
// tb_imem_program_encoder
// Directed scenarios with literal instruction words, then randomized sessions,
// all compared every cycle against a behavioural model of the programmer.
// -----------------------------------------------------------------------------
module tb_imem_program_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cpu_hold, done, err, overflow;
    logic [CW-1:0] word_count;

    imem_program_encoder_if bus ();

    imem_program_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .bus          (bus),
        .o_cpu_hold   (cpu_hold),
        .o_done       (done),
        .o_err        (err),
        .o_overflow   (overflow),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int unsigned fld(input int unsigned x, input int hi, input int lo);
        return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
    endfunction

    function automatic bit model_legal(input int unsigned kind, input int unsigned f3,
                                       input bit alt, input int unsigned imm);
        bit ok;
        case (kind)
            0, 1:    ok = 1'b1;
            2, 3:    ok = ((32'hF3 >> f3) & 1) != 0;              // f3 2,3 rejected
            4:       ok = (((32'h13 >> f3) & 1) != 0) && ((imm & 1) == 0);
            default: ok = 1'b0;
        endcase
        if (alt && !(kind == 2 && f3 == 0)) ok = 1'b0;
        return ok;
    endfunction

    function automatic int unsigned model_word(input int unsigned kind, input int unsigned f3,
                                               input bit alt, input int unsigned rd,
                                               input int unsigned rs1, input int unsigned rs2,
                                               input int unsigned imm);
        int unsigned w;
        case (kind)
            0: w = (fld(imm, 11, 0) << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 'h03;
            1: w = (fld(imm, 11, 5) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12)
                 + (fld(imm, 4, 0) << 7) + 'h23;
            2: w = (int'(alt) << 30) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
            3: w = (((f3 == 1) || (f3 == 5)) ? (fld(imm, 4, 0) << 20) : (fld(imm, 11, 0) << 20))
                 + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
            default: w = (fld(imm, 12, 12) << 31) + (fld(imm, 10, 5) << 25) + (rs2 << 20)
                 + (rs1 << 15) + (f3 << 12) + (fld(imm, 4, 1) << 8) + (fld(imm, 11, 11) << 7) + 'h63;
        endcase
        return w;
    endfunction

    // phase: 0 idle, 1 programming, 2 done
    int          m_phase = 0;
    bit          m_closed, m_done, m_hold, m_err, m_ovf, m_we, m_live = 1'b0;
    int          m_idx, m_wc;
    logic [31:0] m_addr, m_wdata;
    bit          m_ready_pre, m_legal;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_closed = 0; m_done = 0; m_hold = 1; m_err = 0; m_ovf = 0;
            m_we = 0; m_idx = 0; m_wc = 0; m_addr = BASE; m_wdata = 32'h0; m_live = 1;
        end else if (m_live) begin
            m_ready_pre = (m_phase == 1) && !m_closed;
            if (m_we) m_wc++;
            m_we = 0;
            if (m_phase == 1 && m_closed) begin
                m_phase = 2; m_done = 1; m_hold = 0;
            end else if (m_phase != 1 && start) begin
                m_phase = 1; m_closed = 0; m_idx = 0; m_wc = 0;
                m_err = 0; m_ovf = 0; m_done = 0; m_hold = 1;
            end else if (m_ready_pre && bus.cmd_valid) begin
                m_legal = model_legal(bus.cmd_kind, bus.cmd_funct3, bus.cmd_alt, bus.cmd_imm);
                if (m_legal) begin
                    m_we    = 1;
                    m_addr  = BASE + 32'(4 * m_idx);
                    m_wdata = model_word(bus.cmd_kind, bus.cmd_funct3, bus.cmd_alt, bus.cmd_rd,
                                         bus.cmd_rs1, bus.cmd_rs2, bus.cmd_imm);
                    m_idx++;
                end else begin
                    m_err = 1;
                end
                if (bus.cmd_last || (m_legal && m_idx == DEPTH)) begin
                    m_closed = 1;
                    if (!bus.cmd_last) m_ovf = 1;
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("cmd_ready",  32'(bus.cmd_ready), 32'((m_phase == 1) && !m_closed));
            check("imem_we",    32'(bus.imem_we),   32'(m_we));
            check("imem_addr",  bus.imem_addr,      m_addr);
            check("imem_wdata", bus.imem_wdata,     m_wdata);
            check("cpu_hold",   32'(cpu_hold),      32'(m_hold));
            check("done",       32'(done),          32'(m_done));
            check("err",        32'(err),           32'(m_err));
            check("overflow",   32'(overflow),      32'(m_ovf));
            check("word_count", 32'(word_count),    32'(m_wc));
        end
    end

    // Log of observed writes for the directed scenarios.
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t wlog[$];
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) wlog.push_back('{bus.imem_addr, bus.imem_wdata});
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic set_cmd(input int kind, input int f3, input bit alt, input int rd,
                           input int rs1, input int rs2, input int imm, input bit last);
        bus.cmd_kind = 3'(kind); bus.cmd_funct3 = 3'(f3); bus.cmd_alt = alt;
        bus.cmd_rd = 5'(rd); bus.cmd_rs1 = 5'(rs1); bus.cmd_rs2 = 5'(rs2);
        bus.cmd_imm = 13'(imm); bus.cmd_last = last;
    endtask

    // Offers one command; returns when it is taken, when the session can no
    // longer take it, or after a bounded wait.
    task automatic send(input int kind, input int f3, input bit alt, input int rd,
                        input int rs1, input int rs2, input int imm, input bit last,
                        output bit accepted);
        bit acc, quit;
        accepted = 1'b0;
        set_cmd(kind, f3, alt, rd, rs1, rs2, imm, last);
        bus.cmd_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            acc  = bus.cmd_ready;
            quit = !acc && ((m_phase != 1) || m_closed);
            tick();
            if (acc) begin accepted = 1'b1; break; end
            if (quit) break;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        check(name, 32'(seen), 32'd1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] exp_mix [4] = '{32'h0040A283, 32'h0020A423, 32'h402081B3, 32'hFE208CE3};

    initial begin
        bit acc;
        int n;
        bus.cmd_valid = 1'b0;
        set_cmd(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; tick(); tick(); rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_ready",    32'(bus.cmd_ready), 32'd0);
        check("rst_addr",     bus.imem_addr, BASE);
        check("rst_wdata",    bus.imem_wdata, 32'h0);
        check("rst_count",    32'(word_count), 32'd0);
        tick();

        // addi x1, x0, 5 as the whole session
        pulse_start();
        @(negedge clk); check("start_ready", 32'(bus.cmd_ready), 32'd1); tick();
        wlog.delete();
        send(3, 0, 0, 1, 0, 0, 5, 1, acc);
        check("addi_accept", 32'(acc), 32'd1);
        @(negedge clk);
        check("addi_we", 32'(bus.imem_we), 32'd1);
        check("addi_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("addi_done", 32'(done), 32'd1);
        check("addi_hold", 32'(cpu_hold), 32'd0);
        check("addi_count", 32'(word_count), 32'd1);
        tick();
        check("addi_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            check("addi_addr", wlog[0].addr, BASE);
            check("addi_word", wlog[0].data, 32'h00500093);
        end

        // Overflow: five non-last legal commands into a 4-word memory
        pulse_start();
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            send(3, 0, 0, i + 1, 0, 0, i * 3, 0, acc);
            check("ovf_accept", 32'(acc), 32'd1);
        end
        set_cmd(3, 0, 0, 9, 0, 0, 7, 0);
        bus.cmd_valid = 1'b1;
        repeat (3) begin @(negedge clk); check("ovf_fifth_ready", 32'(bus.cmd_ready), 32'd0); end
        tick();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_done", 32'(done), 32'd1);
        check("ovf_count", 32'(word_count), 32'd4);
        tick();
        check("ovf_nwrites", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < wlog.size() && i < 4; i++) check("ovf_addr", wlog[i].addr, BASE + 32'(4 * i));

        // Illegal R f3=010 then addi (last)
        pulse_start();
        @(negedge clk);
        check("restart_done_clr", 32'(done), 32'd0);
        check("restart_hold", 32'(cpu_hold), 32'd1);
        check("restart_ovf_clr", 32'(overflow), 32'd0);
        tick();
        wlog.delete();
        send(2, 2, 0, 4, 1, 2, 0, 0, acc);
        check("illegal_accept", 32'(acc), 32'd1);
        send(3, 0, 0, 1, 0, 0, 5, 1, acc);
        wait_done("illegal_done_seen");
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_count", 32'(word_count), 32'd1);
        check("illegal_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            check("illegal_addr", wlog[0].addr, BASE);
            check("illegal_word", wlog[0].data, 32'h00500093);
        end

        // Restart from DONE, then back-to-back mix with valid held
        pulse_start();
        @(negedge clk);
        check("restart2_err_clr", 32'(err), 32'd0);
        check("restart2_done_clr", 32'(done), 32'd0);
        tick();
        wlog.delete();
        send(0, 0, 0, 5, 1, 0, 4, 0, acc);           // lw  x5, 4(x1)
        send(1, 0, 0, 0, 1, 2, 8, 0, acc);           // sw  x2, 8(x1)
        send(2, 0, 1, 3, 1, 2, 0, 0, acc);           // sub x3, x1, x2
        send(4, 0, 0, 0, 1, 2, 13'h1FF8, 1, acc);    // beq x1, x2, -8
        wait_done("mix_done_seen");
        check("mix_count", 32'(word_count), 32'd4);
        check("mix_nwrites", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < wlog.size() && i < 4; i++) begin
            check("mix_addr", wlog[i].addr, BASE + 32'(4 * i));
            check("mix_word", wlog[i].data, exp_mix[i]);
        end

        // Reset one cycle after the second accept
        pulse_start();
        wlog.delete();
        send(3, 0, 0, 1, 0, 0, 1, 0, acc);
        send(3, 0, 0, 2, 0, 0, 2, 0, acc);
        set_cmd(3, 0, 0, 3, 0, 0, 3, 0);
        bus.cmd_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("mrst_we", 32'(bus.imem_we), 32'd0);
        check("mrst_count", 32'(word_count), 32'd0);
        check("mrst_hold", 32'(cpu_hold), 32'd1);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        tick();
        @(negedge clk); check("mrst_idle_ready", 32'(bus.cmd_ready), 32'd0); tick();
        check("mrst_nwrites", 32'(wlog.size()), 32'd2);

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            pulse_start();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                int kind, imm;
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
                if ($urandom_range(0, 9) == 0) pulse_start();
                kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
                imm  = int'($urandom_range(0, 8191));
                if (kind == 4 && $urandom_range(0, 4) != 0) imm = imm & 'h1FFE;
                send(kind, $urandom_range(0, 7), ($urandom_range(0, 5) == 0),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     imm, (i == n - 1), acc);
                if (!acc) break;
            end
            wait_done("rand_done_seen");
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
